cpu8_sequencer: RTL and testbench

//  Control unit for the 8-bit accumulator CPU. Fetches and decodes the 8-bit ISA, owns IP, drives
//  the memory address and write strobe, and issues ALU op, B-source select and register/flag write

---
 rtl/cpu8_pkg.sv | 39 +++
 rtl/cpu8_branch_eval.sv | 20 ++
 rtl/cpu8_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cpu8_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Purpose: shared encodings for the 8-bit accumulator CPU control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu8_pkg;

    // FSM state encodings; the value is exported on the debug state port.
    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_SELECT  = 3'd1,
        S_DECODE  = 3'd2,
        S_COMPUTE = 3'd3,
        S_READ_IP = 3'd4
    } state_t;

    // Destination field opcode[5:4] of ALU-class instructions.
    localparam logic [1:0] DEST_A     = 2'b00;
    localparam logic [1:0] DEST_B     = 2'b01;
    localparam logic [1:0] DEST_IP    = 2'b10;
    localparam logic [1:0] DEST_FLAGS = 2'b11;

    // ALU op that forwards the B operand (used by load-immediate forms).
    localparam logic [3:0] OP_PASS_B = 4'hB;

    // Opcode classes selected by opcode[7:6].
    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_MISC    = 2'b10;
    localparam logic [1:0] CLS_ALU_IND = 2'b11;

    // Sub-classes of the misc class, selected by opcode[5:4].
    localparam logic [1:0] MISC_STORE  = 2'b01;
    localparam logic [1:0] MISC_BRANCH = 2'b10;

    // Exact misc opcodes.
    localparam logic [7:0] OPC_SWAP  = 8'h81;
    localparam logic [7:0] OPC_CLC   = 8'h88;
    localparam logic [7:0] OPC_RESET = 8'hBF;

endpackage

// File: rtl/cpu8_branch_eval.sv
// Purpose: evaluates a branch condition nibble against the datapath flags.
// Latency: combinational.
// Backpressure: none.
// Ports: cond_i = tttt {zv,zu,cv,cu}; zero_i/carry_i = flags; take_o = branch taken.
module cpu8_branch_eval (
    input  logic [3:0] cond_i,
    input  logic       zero_i,
    input  logic       carry_i,
    output logic       take_o
);
    import cpu8_pkg::*;

    logic zv, zu, cv, cu;

    assign {zv, zu, cv, cu} = cond_i;

    // A flag is only tested when its "use" bit is set; 0000 is unconditional.
    assign take_o = (!zu || (zero_i == zv)) && (!cu || (carry_i == cv));

endmodule

// File: rtl/cpu8_sequencer.sv
// Purpose: fetch/decode/sequence unit of the 8-bit accumulator CPU; owns IP and memory address/strobe.
// Latency: ALU/imm/indirect/branch 3 cycles, store/swap/clc 2 cycles (+1 write cycle) when mem_ready=1.
// Backpressure: any memory-dependent state holds (no strobes) while mem_ready=0.
// Ports: clk/reset (sync, active-high); mem_rdata/mem_ready from memory; alu_y, b_reg, zero, carry
//        from datapath; mem_addr/mem_write to memory; alu_op, b_src, a_we, b_we, flags_we, swap_ab,
//        carry_clr to datapath; ip/state for debug.
module cpu8_sequencer #(
    parameter logic [7:0] RESET_VEC  = 8'h80,
    parameter logic [3:0] STORE_PAGE = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    input  logic [8:0] alu_y,
    input  logic [7:0] b_reg,
    input  logic       zero,
    input  logic       carry,
    output logic [7:0] mem_addr,
    output logic       mem_write,
    output logic [3:0] alu_op,
    output logic       b_src,
    output logic       a_we,
    output logic       b_we,
    output logic       flags_we,
    output logic       swap_ab,
    output logic       carry_clr,
    output logic [7:0] ip,
    output logic [2:0] state
);
    import cpu8_pkg::*;

    state_t     state_q, state_d;
    logic [7:0] ip_q, ip_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic       mem_write_q, mem_write_d;
    logic [7:0] opcode_q, opcode_d;
    logic       take_q, take_d;

    logic       a_we_c, b_we_c, flags_we_c, swap_c, clc_c;
    logic       take_c;

    // Carry out of the ALU and the top opcode bit are not needed by the sequencer.
    logic       unused_bits;
    assign unused_bits = alu_y[8] ^ opcode_q[7];

    cpu8_branch_eval u_branch (
        .cond_i  (mem_rdata[3:0]),
        .zero_i  (zero),
        .carry_i (carry),
        .take_o  (take_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RESET;
            ip_q        <= RESET_VEC;
            mem_addr_q  <= 8'h00;
            mem_write_q <= 1'b0;
            opcode_q    <= 8'h00;
            take_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            opcode_q    <= opcode_d;
            take_q      <= take_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        opcode_d    = opcode_q;
        take_d      = take_q;
        a_we_c      = 1'b0;
        b_we_c      = 1'b0;
        flags_we_c  = 1'b0;
        swap_c      = 1'b0;
        clc_c       = 1'b0;

        case (state_q)
            S_RESET: begin
                ip_d    = RESET_VEC;
                state_d = S_SELECT;
            end

            S_SELECT: begin
                // A pending store must be accepted before the next fetch address goes out.
                if (!(mem_write_q && !mem_ready)) begin
                    mem_addr_d  = ip_q;
                    ip_d        = ip_q + 8'd1;
                    mem_write_d = 1'b0;
                    state_d     = S_DECODE;
                end
            end

            S_DECODE: begin
                if (mem_ready) begin
                    opcode_d = mem_rdata;
                    state_d  = S_SELECT;
                    case (mem_rdata[7:6])
                        CLS_ALU_REG: state_d = S_COMPUTE;
                        CLS_ALU_IMM: begin
                            mem_addr_d = ip_q;
                            ip_d       = ip_q + 8'd1;
                            state_d    = S_COMPUTE;
                        end
                        CLS_ALU_IND: begin
                            mem_addr_d = b_reg;
                            state_d    = S_COMPUTE;
                        end
                        default: begin
                            if (mem_rdata[5:4] == MISC_STORE) begin
                                mem_addr_d  = {STORE_PAGE, mem_rdata[3:0]};
                                mem_write_d = 1'b1;
                            end else if (mem_rdata[5:4] == MISC_BRANCH) begin
                                take_d     = take_c;
                                mem_addr_d = ip_q;
                                ip_d       = ip_q + 8'd1;
                                state_d    = S_READ_IP;
                            end else if (mem_rdata == OPC_SWAP) begin
                                swap_c = 1'b1;
                            end else if (mem_rdata == OPC_CLC) begin
                                clc_c = 1'b1;
                            end else if (mem_rdata == OPC_RESET) begin
                                state_d = S_RESET;
                            end
                        end
                    endcase
                end
            end

            S_COMPUTE: begin
                // Only memory-sourced operands (imm/indirect) have to wait for memory.
                if (!(opcode_q[6] && !mem_ready)) begin
                    flags_we_c = 1'b1;
                    case (opcode_q[5:4])
                        DEST_A:  a_we_c = 1'b1;
                        DEST_B:  b_we_c = 1'b1;
                        DEST_IP: ip_d   = alu_y[7:0];
                        default: ;
                    endcase
                    state_d = S_SELECT;
                end
            end

            S_READ_IP: begin
                if (mem_ready) begin
                    if (take_q) begin
                        ip_d = mem_rdata;
                    end
                    state_d = S_SELECT;
                end
            end

            default: state_d = S_RESET;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign alu_op    = opcode_q[3:0];
    assign b_src     = opcode_q[6];
    assign ip        = ip_q;
    assign state     = state_q;

    // Strobes are suppressed outright in any cycle where reset is asserted.
    assign a_we      = a_we_c     & ~reset;
    assign b_we      = b_we_c     & ~reset;
    assign flags_we  = flags_we_c & ~reset;
    assign swap_ab   = swap_c     & ~reset;
    assign carry_clr = clc_c      & ~reset;

endmodule

// File: tb/tb_cpu8_sequencer.sv
module tb_cpu8_sequencer;

    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_READ_IP = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b1;
    logic [8:0] alu_y = 9'h005;
    logic [7:0] b_reg = 8'h40;
    logic       zero = 1'b0;
    logic       carry = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       b_src;
    logic       a_we, b_we, flags_we, swap_ab, carry_clr;
    logic [7:0] ip;
    logic [2:0] state;

    logic [7:0] mem [0:255];
    int total = 0;
    int bad = 0;

    // {a_we, b_we, flags_we, swap_ab, carry_clr}
    logic [4:0] strb;
    assign strb = {a_we, b_we, flags_we, swap_ab, carry_clr};
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    cpu8_sequencer #(.RESET_VEC(8'h80), .STORE_PAGE(4'h0)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_y(alu_y), .b_reg(b_reg), .zero(zero), .carry(carry),
        .mem_addr(mem_addr), .mem_write(mem_write), .alu_op(alu_op), .b_src(b_src),
        .a_we(a_we), .b_we(b_we), .flags_we(flags_we), .swap_ab(swap_ab),
        .carry_clr(carry_clr), .ip(ip), .state(state)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
    endtask

    // Leaves reset deasserted at a falling edge; the next rising edge leaves S_RESET.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        cyc();
        cyc();
        total++; if (state !== ST_RESET) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, ST_RESET); end
        total++; if (ip !== 8'h80) begin bad++; $display("FAIL reset_ip got=%h want=80", ip); end
        total++; if (mem_addr !== 8'h00 || mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem got=%h/%b want=00/0", mem_addr, mem_write); end
        total++; if (strb !== 5'b0 || alu_op !== 4'h0) begin bad++; $display("FAIL reset_strobes got=%b op=%h want=00000 op=0", strb, alu_op); end
        reset = 1'b0;
        cyc();
        total++; if (state !== ST_SELECT || ip !== 8'h80) begin bad++; $display("FAIL reset_exit got=%0d/%h want=%0d/80", state, ip, ST_SELECT); end
    endtask

    task automatic test_load_imm();
        clear_mem();
        mem[8'h80] = 8'h4B; mem[8'h81] = 8'h05;
        alu_y = 9'h005;
        do_reset();
        cyc(); // SELECT
        cyc(); // DECODE
        total++; if (state !== ST_DECODE || mem_addr !== 8'h80 || ip !== 8'h81) begin bad++; $display("FAIL imm_decode got=%0d/%h/%h want=%0d/80/81", state, mem_addr, ip, ST_DECODE); end
        cyc(); // COMPUTE
        total++; if (state !== ST_COMPUTE || mem_addr !== 8'h81 || ip !== 8'h82) begin bad++; $display("FAIL imm_compute got=%0d/%h/%h want=%0d/81/82", state, mem_addr, ip, ST_COMPUTE); end
        total++; if (strb !== 5'b10100) begin bad++; $display("FAIL imm_strobes got=%b want=10100", strb); end
        total++; if (alu_op !== 4'hB || b_src !== 1'b1) begin bad++; $display("FAIL imm_op got=%h/%b want=b/1", alu_op, b_src); end
        cyc();
        total++; if (state !== ST_SELECT || strb !== 5'b0) begin bad++; $display("FAIL imm_done got=%0d/%b want=%0d/00000", state, strb, ST_SELECT); end
    endtask

    task automatic test_store();
        clear_mem();
        mem[8'h80] = 8'h93;
        do_reset();
        cyc(); // SELECT
        cyc(); // DECODE
        cyc(); // back in SELECT with write
        total++; if (state !== ST_SELECT || mem_addr !== 8'h03 || mem_write !== 1'b1) begin bad++; $display("FAIL store_write got=%0d/%h/%b want=%0d/03/1", state, mem_addr, mem_write, ST_SELECT); end
        total++; if (strb !== 5'b0) begin bad++; $display("FAIL store_strobes got=%b want=00000", strb); end
        cyc();
        total++; if (mem_write !== 1'b0 || mem_addr !== 8'h81 || ip !== 8'h82) begin bad++; $display("FAIL store_end got=%b/%h/%h want=0/81/82", mem_write, mem_addr, ip); end
    endtask

    task automatic test_branch(input logic c, input logic [7:0] want_ip);
        clear_mem();
        mem[8'h80] = 8'hA3; mem[8'h81] = 8'h90;
        carry = c;
        do_reset();
        cyc(); // SELECT
        cyc(); // DECODE
        cyc(); // READ_IP
        total++; if (state !== ST_READ_IP || mem_addr !== 8'h81) begin bad++; $display("FAIL branch_read got=%0d/%h want=%0d/81", state, mem_addr, ST_READ_IP); end
        cyc();
        total++; if (state !== ST_SELECT || ip !== want_ip) begin bad++; $display("FAIL branch_ip c=%b got=%0d/%h want=%0d/%h", c, state, ip, ST_SELECT, want_ip); end
        carry = 1'b0;
    endtask

    task automatic test_stall();
        clear_mem();
        mem[8'h80] = 8'h4B; mem[8'h81] = 8'h05;
        do_reset();
        cyc(); // SELECT
        cyc(); // DECODE
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (state !== ST_DECODE || ip !== 8'h81 || alu_op !== 4'h0 || b_src !== 1'b0 || strb !== 5'b0) begin
                bad++; $display("FAIL stall_hold[%0d] got=%0d/%h/%h/%b want=%0d/81/0/00000", i, state, ip, alu_op, strb, ST_DECODE);
            end
            cyc();
        end
        total++; if (state !== ST_DECODE || ip !== 8'h81) begin bad++; $display("FAIL stall_last got=%0d/%h want=%0d/81", state, ip, ST_DECODE); end
        mem_ready = 1'b1;
        cyc();
        total++; if (state !== ST_COMPUTE || ip !== 8'h82 || strb !== 5'b10100 || alu_op !== 4'hB) begin bad++; $display("FAIL stall_resume got=%0d/%h/%b/%h want=%0d/82/10100/b", state, ip, strb, alu_op, ST_COMPUTE); end
    endtask

    task automatic test_indirect();
        clear_mem();
        mem[8'h80] = 8'hC5;
        b_reg = 8'h40;
        do_reset();
        cyc(); // SELECT
        cyc(); // DECODE
        cyc(); // COMPUTE
        mem_ready = 1'b0;
        #1;
        total++; if (state !== ST_COMPUTE || mem_addr !== 8'h40 || strb !== 5'b0) begin bad++; $display("FAIL ind_wait got=%0d/%h/%b want=%0d/40/00000", state, mem_addr, strb, ST_COMPUTE); end
        cyc();
        total++; if (state !== ST_COMPUTE || strb !== 5'b0) begin bad++; $display("FAIL ind_hold got=%0d/%b want=%0d/00000", state, strb, ST_COMPUTE); end
        mem_ready = 1'b1;
        #1;
        total++; if (strb !== 5'b10100 || alu_op !== 4'h5 || b_src !== 1'b1) begin bad++; $display("FAIL ind_fire got=%b/%h/%b want=10100/5/1", strb, alu_op, b_src); end
        cyc();
        total++; if (state !== ST_SELECT || ip !== 8'h81) begin bad++; $display("FAIL ind_done got=%0d/%h want=%0d/81", state, ip, ST_SELECT); end
    endtask

    task automatic test_swap_clc();
        clear_mem();
        mem[8'h80] = 8'h81; mem[8'h81] = 8'h88;
        do_reset();
        cyc(); // SELECT
        cyc(); // DECODE 81
        total++; if (strb !== 5'b00010) begin bad++; $display("FAIL swap_strobe got=%b want=00010", strb); end
        cyc(); // SELECT
        total++; if (state !== ST_SELECT || strb !== 5'b0) begin bad++; $display("FAIL swap_after got=%0d/%b want=%0d/00000", state, strb, ST_SELECT); end
        cyc(); // DECODE 88
        total++; if (strb !== 5'b00001 || ip !== 8'h82) begin bad++; $display("FAIL clc_strobe got=%b/%h want=00001/82", strb, ip); end
    endtask

    task automatic test_wrap_and_reset_op();
        clear_mem();
        mem[8'h80] = 8'hA0; mem[8'h81] = 8'hFE;
        mem[8'hFE] = 8'h6B; mem[8'hFF] = 8'hFF;
        mem[8'h00] = 8'hBF;
        alu_y = 9'h100; // DEST_IP takes only the low byte
        do_reset();
        cyc(); cyc(); cyc(); // SELECT, DECODE, READ_IP
        cyc(); // SELECT
        total++; if (ip !== 8'hFE) begin bad++; $display("FAIL wrap_jump got=%h want=fe", ip); end
        cyc(); // DECODE at FE
        cyc(); // COMPUTE, imm fetched at FF
        total++; if (state !== ST_COMPUTE || mem_addr !== 8'hFF || ip !== 8'h00) begin bad++; $display("FAIL wrap_fetch got=%0d/%h/%h want=%0d/ff/00", state, mem_addr, ip, ST_COMPUTE); end
        total++; if (strb !== 5'b00100) begin bad++; $display("FAIL wrap_strobes got=%b want=00100", strb); end
        cyc(); // SELECT, ip <= alu_y[7:0]
        total++; if (state !== ST_SELECT || ip !== 8'h00) begin bad++; $display("FAIL dest_ip got=%0d/%h want=%0d/00", state, ip, ST_SELECT); end
        cyc(); // DECODE BF at 00
        cyc();
        total++; if (state !== ST_RESET) begin bad++; $display("FAIL opc_reset got=%0d want=%0d", state, ST_RESET); end
        cyc();
        total++; if (state !== ST_SELECT || ip !== 8'h80) begin bad++; $display("FAIL opc_reset_ip got=%0d/%h want=%0d/80", state, ip, ST_SELECT); end
        alu_y = 9'h005;
    endtask

    task automatic test_reset_midwrite();
        clear_mem();
        mem[8'h80] = 8'h9A;
        do_reset();
        cyc(); cyc(); cyc(); // SELECT, DECODE, SELECT with write
        total++; if (mem_write !== 1'b1 || mem_addr !== 8'h0A) begin bad++; $display("FAIL midw_pre got=%b/%h want=1/0a", mem_write, mem_addr); end
        reset = 1'b1;
        #1;
        total++; if (strb !== 5'b0) begin bad++; $display("FAIL midw_gate got=%b want=00000", strb); end
        cyc();
        total++; if (mem_write !== 1'b0 || state !== ST_RESET || mem_addr !== 8'h00) begin bad++; $display("FAIL midw_post got=%b/%0d/%h want=0/%0d/00", mem_write, state, mem_addr, ST_RESET); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_store();
        test_branch(1'b1, 8'h90);
        test_branch(1'b0, 8'h82);
        test_stall();
        test_indirect();
        test_swap_clc();
        test_wrap_and_reset_op();
        test_reset_midwrite();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
